// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter: serialises refresh, sensor-write and downlink-read commands onto one SDRAM controller over a 24-bit circular buffer.
// Ports:
//   CLK_48MHZ, RESET           clock and synchronous active-high reset
//   REFRESH_REQ/WR_REQ/RD_REQ  level requests, each held until its ACK
//   CMD_DONE                   controller pulse: outstanding command finished
//   CMD_START, CMD_TYPE        launch pulse and command type (01 wr, 10 rd, 11 ref)
//   BA_OUT/COL_OUT/ROW_OUT     command address split from the 24-bit pointer
//   WR_ACK/RD_ACK/REF_ACK      completion pulses
//   EMPTY, FULL, FILL_LEVEL    buffer occupancy
//   OVR_CNT                    saturating count of words lost to overwrite
module sdram_access_arbiter #(
    parameter int OVR_CNT_W = 8
) (
    input  logic                 CLK_48MHZ,
    input  logic                 RESET,
    input  logic                 REFRESH_REQ,
    input  logic                 WR_REQ,
    input  logic                 RD_REQ,
    input  logic                 CMD_DONE,
    output logic                 CMD_START,
    output logic [1:0]           CMD_TYPE,
    output logic [1:0]           BA_OUT,
    output logic [8:0]           COL_OUT,
    output logic [12:0]          ROW_OUT,
    output logic                 WR_ACK,
    output logic                 RD_ACK,
    output logic                 REF_ACK,
    output logic                 EMPTY,
    output logic                 FULL,
    output logic [24:0]          FILL_LEVEL,
    output logic [OVR_CNT_W-1:0] OVR_CNT
);
    localparam logic [1:0] T_NONE = 2'b00, T_WR = 2'b01, T_RD = 2'b10, T_REF = 2'b11;
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, state_nxt;
    logic last_rd, rd_ok, issue, done;
    logic [1:0] gnt;
    logic [23:0] wp, rp, wp_nxt, rp_nxt, ptr;
    logic [24:0] fill_nxt;
    logic [OVR_CNT_W-1:0] ovr_nxt;
    always_comb begin
        rd_ok = RD_REQ && !EMPTY;
        // refresh always wins; a write/read tie goes to whoever was not served last
        gnt = REFRESH_REQ ? T_REF : (WR_REQ && (!rd_ok || last_rd)) ? T_WR : rd_ok ? T_RD : T_NONE;
        // requesters still see their request high during the ACK cycle, so never grant then
        issue = state == S_IDLE && !(WR_ACK || RD_ACK || REF_ACK) && gnt != T_NONE;
        done = state == S_WAIT && CMD_DONE && !CMD_START;
        state_nxt = issue ? S_WAIT : done ? S_IDLE : state;
        ptr = gnt == T_WR ? wp : gnt == T_RD ? rp : 24'd0;
        wp_nxt = wp;
        rp_nxt = rp;
        fill_nxt = FILL_LEVEL;
        ovr_nxt = OVR_CNT;
        if (done && CMD_TYPE == T_WR) begin
            wp_nxt = wp + 24'd1;
            // a write into a full buffer drops the oldest word
            rp_nxt = FULL ? rp + 24'd1 : rp;
            fill_nxt = FULL ? FILL_LEVEL : FILL_LEVEL + 25'd1;
            ovr_nxt = (FULL && !(&OVR_CNT)) ? OVR_CNT + 1'b1 : OVR_CNT;
        end else if (done && CMD_TYPE == T_RD) begin
            rp_nxt = rp + 24'd1;
            fill_nxt = FILL_LEVEL - 25'd1;
        end
    end
    always_ff @(posedge CLK_48MHZ) begin
        if (RESET) state <= S_IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge CLK_48MHZ) begin
        if (RESET) begin
            CMD_START <= 1'b0;
            CMD_TYPE <= T_NONE;
            {BA_OUT, COL_OUT, ROW_OUT} <= 24'd0;
            {WR_ACK, RD_ACK, REF_ACK} <= 3'b000;
            wp <= 24'd0;
            rp <= 24'd0;
            FILL_LEVEL <= 25'd0;
            EMPTY <= 1'b1;
            FULL <= 1'b0;
            OVR_CNT <= '0;
            last_rd <= 1'b1;
        end else begin
            CMD_START <= issue;
            WR_ACK <= done && CMD_TYPE == T_WR;
            RD_ACK <= done && CMD_TYPE == T_RD;
            REF_ACK <= done && CMD_TYPE == T_REF;
            wp <= wp_nxt;
            rp <= rp_nxt;
            FILL_LEVEL <= fill_nxt;
            EMPTY <= fill_nxt == 25'd0;
            FULL <= fill_nxt[24];
            OVR_CNT <= ovr_nxt;
            if (issue) begin
                CMD_TYPE <= gnt;
                {BA_OUT, COL_OUT, ROW_OUT} <= ptr;
                if (gnt != T_REF) last_rd <= gnt == T_RD;
            end else if (done) begin
                CMD_TYPE <= T_NONE;
                {BA_OUT, COL_OUT, ROW_OUT} <= 24'd0;
            end
        end
    end
endmodule
